// File: rtl/fifo_packer_if.sv
// fifo_packer_if
//   Bundles the two handshakes of the FIFO packer.
//   Upstream side:   fifo_dout, fifo_empty_n (from a show-ahead FIFO), fifo_deq (pop request).
//   Downstream side: out_data, out_valid, out_ready, plus the delivered-vector counter pkt_count.
//   slave  modport: the packer itself.
//   master modport: the environment (FIFO + consumer).
interface fifo_packer_if #(
    parameter int DATA_WIDTH = 11,
    parameter int NUM_WORDS  = 25
);
    logic [DATA_WIDTH-1:0]           fifo_dout;
    logic                            fifo_empty_n;
    logic                            fifo_deq;
    logic [DATA_WIDTH*NUM_WORDS-1:0] out_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [15:0]                     pkt_count;

    modport slave (
        input  fifo_dout, fifo_empty_n, out_ready,
        output fifo_deq, out_data, out_valid, pkt_count
    );

    modport master (
        output fifo_dout, fifo_empty_n, out_ready,
        input  fifo_deq, out_data, out_valid, pkt_count
    );
endinterface

// File: rtl/fifo_packer.sv
// fifo_packer
//   Pops words from an upstream show-ahead FIFO and packs NUM_WORDS of them
//   into one wide vector (word i at bits [i*DATA_WIDTH +: DATA_WIDTH]),
//   presented through a valid/ready output register.
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   clr    - synchronous active-high clear (does not touch pkt_count)
//   bus    - fifo_packer_if.slave: FIFO pop side, packed output side, pkt_count
module fifo_packer #(
    parameter int DATA_WIDTH = 11,
    parameter int NUM_WORDS  = 25,
    parameter int CNT_WIDTH  = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    fifo_packer_if.slave  bus
);
    localparam int VEC_W = DATA_WIDTH * NUM_WORDS;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(NUM_WORDS - 1);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [VEC_W-1:0]     acc_q, acc_d;
    logic [VEC_W-1:0]     out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic [15:0]          pkt_count_q, pkt_count_d;
    logic                 deq;
    logic                 handshake;

    // Pop only while collecting; in HOLD the collect buffer is full.
    assign deq       = bus.fifo_empty_n && (state_q == COLLECT) && !clr;
    assign handshake = out_valid_q && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        // The counter tracks deliveries, independent of clr.
        pkt_count_d = pkt_count_q + 16'(handshake);

        if (clr) begin
            state_d     = COLLECT;
            cnt_d       = '0;
            acc_d       = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
        end else begin
            // A delivery frees the output register; a load below overrides this.
            if (handshake) begin
                out_valid_d = 1'b0;
            end
            unique case (state_q)
                COLLECT: begin
                    if (deq) begin
                        if (cnt_q == LAST) begin
                            if (!out_valid_q || bus.out_ready) begin
                                // Bypass acc: last word goes straight into the output vector.
                                out_data_d  = {bus.fifo_dout, acc_q[VEC_W-DATA_WIDTH-1:0]};
                                out_valid_d = 1'b1;
                                cnt_d       = '0;
                            end else begin
                                acc_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_dout;
                                state_d = HOLD;
                            end
                        end else begin
                            acc_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_dout;
                            cnt_d = cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
                HOLD: begin
                    // out_valid is necessarily 1 here, so out_ready alone is the handshake.
                    if (bus.out_ready) begin
                        out_data_d  = acc_q;
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = COLLECT;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign bus.fifo_deq  = deq;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.pkt_count = pkt_count_q;
endmodule

// File: tb/tb_fifo_packer.sv
// tb_fifo_packer
//   Bench for fifo_packer with DATA_WIDTH=4, NUM_WORDS=3 and a 3-deep
//   upstream show-ahead FIFO modelled here. The reference model tracks
//   popped words in groups of three and a queue of completed, undelivered
//   vectors (at most two: output register plus a full collect buffer).
module tb_fifo_packer;
    localparam int DW = 4;
    localparam int NW = 3;
    localparam int CW = 2;
    localparam int VW = DW * NW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;

    always #5 clk = ~clk;

    fifo_packer_if #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) bus ();

    fifo_packer #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Upstream FIFO storage (depth 3, circular over 8 slots)
    logic [DW-1:0] mem [8];
    int wr = 0;
    int rd = 0;
    logic [DW-1:0] feed [$];

    // Reference model state
    logic [VW-1:0] outq [$];
    logic [DW-1:0] part [$];
    int unsigned   mpkt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.fifo_empty_n = (wr != rd);
        bus.fifo_dout    = (wr != rd) ? mem[rd % 8] : '0;
    endtask

    task automatic model_clear();
        outq.delete();
        part.delete();
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic step(input bit rdy, input bit c);
        bit            exp_deq, hs, deq_act;
        logic [DW-1:0] head;
        if (feed.size() > 0 && (wr - rd) < 3) begin
            mem[wr % 8] = feed.pop_front();
            wr++;
        end
        drive_fifo();
        bus.out_ready = rdy;
        clr = c;
        #1;
        exp_deq = (wr != rd) && !c && (outq.size() < 2);
        chk("fifo_deq", 32'(bus.fifo_deq), 32'(exp_deq));
        chk("out_valid", 32'(bus.out_valid), 32'(outq.size() > 0));
        if (outq.size() > 0) chk("out_data", 32'(bus.out_data), 32'(outq[0]));
        chk("pkt_count", 32'(bus.pkt_count), mpkt);
        hs      = (outq.size() > 0) && rdy;
        head    = mem[rd % 8];
        deq_act = bus.fifo_deq;
        @(posedge clk);
        #1;
        if (deq_act && wr != rd) rd++;
        if (hs) mpkt = (mpkt + 1) & 32'hFFFF;
        if (c) begin
            model_clear();
        end else begin
            if (hs) void'(outq.pop_front());
            if (exp_deq) begin
                part.push_back(head);
                if (part.size() == NW) begin
                    outq.push_back({part[2], part[1], part[0]});
                    part.delete();
                end
            end
        end
        drive_fifo();
        clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr = 0;
        rd = 0;
        feed.delete();
        model_clear();
        mpkt = 0;
        drive_fifo();
        bus.out_ready = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data", 32'(bus.out_data), 32'h0);
        chk("rst_pkt_count", 32'(bus.pkt_count), 32'h0);
        chk("rst_fifo_deq", 32'(bus.fifo_deq), 32'h0);
        rst_n = 1'b1;
    endtask

    // Asynchronous reset pulse in the middle of a cycle.
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        wr = rd;
        model_clear();
        mpkt = 0;
        drive_fifo();
        #1;
        chk("async_out_valid", 32'(bus.out_valid), 32'h0);
        chk("async_pkt_count", 32'(bus.pkt_count), 32'h0);
        chk("async_fifo_deq", 32'(bus.fifo_deq), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.out_ready    = 1'b0;
        bus.fifo_empty_n = 1'b0;
        bus.fifo_dout    = '0;
        @(negedge clk);

        // Reset and basic pack
        do_reset();
        feed = '{4'h1, 4'h2, 4'h3};
        repeat (3) step(1'b1, 1'b0);
        chk("basic_valid", 32'(bus.out_valid), 32'h1);
        chk("basic_data", 32'(bus.out_data), 32'h321);
        step(1'b1, 1'b0);
        chk("basic_pkt", 32'(bus.pkt_count), 32'h1);

        // Backpressure into HOLD, then drain
        do_reset();
        feed = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
        repeat (9) step(1'b0, 1'b0);
        chk("bp_data_held", 32'(bus.out_data), 32'h321);
        chk("bp_deq_hold", 32'(bus.fifo_deq), 32'h0);
        step(1'b1, 1'b0);
        chk("bp_second_valid", 32'(bus.out_valid), 32'h1);
        chk("bp_second_data", 32'(bus.out_data), 32'h654);
        step(1'b1, 1'b0);
        chk("bp_pkt", 32'(bus.pkt_count), 32'h2);
        repeat (2) step(1'b1, 1'b0);

        // Underflow stall
        do_reset();
        feed = '{4'h7};
        step(1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0);
        feed = '{4'h8, 4'h9};
        repeat (3) step(1'b0, 1'b0);
        chk("stall_data", 32'(bus.out_data), 32'h987);
        chk("stall_pops", 32'(rd), 32'd3);
        step(1'b1, 1'b0);

        // Synchronous clear mid-vector
        do_reset();
        feed = '{4'h1, 4'h2};
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("clr_valid_low", 32'(bus.out_valid), 32'h0);
        feed = '{4'h4, 4'h5, 4'h6};
        repeat (3) step(1'b0, 1'b0);
        chk("clr_data", 32'(bus.out_data), 32'h654);
        step(1'b1, 1'b0);

        // Asynchronous reset mid-vector
        do_reset();
        feed = '{4'h1, 4'h2};
        repeat (3) step(1'b0, 1'b0);
        pulse_reset();
        feed = '{4'h3, 4'h4, 4'h5};
        repeat (4) step(1'b0, 1'b0);
        chk("rstmid_data", 32'(bus.out_data), 32'h543);
        step(1'b1, 1'b0);
        chk("rstmid_pkt", 32'(bus.pkt_count), 32'h1);

        // Asynchronous reset while in HOLD
        feed = '{4'ha, 4'hb, 4'hc, 4'hd, 4'he, 4'hf};
        repeat (8) step(1'b0, 1'b0);
        pulse_reset();
        feed = '{4'h6, 4'h7, 4'h8};
        repeat (4) step(1'b1, 1'b0);
        chk("rsthold_pkt", 32'(bus.pkt_count), 32'h1);

        // Sustained throughput then randomized traffic
        feed = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'ha, 4'hb, 4'hc};
        repeat (14) step(1'b1, 1'b0);
        for (int i = 0; i < 600; i++) begin
            bit rdy;
            bit c;
            if (feed.size() == 0 && ($urandom % 4) != 0) feed.push_back(4'($urandom));
            rdy = ($urandom % 3) != 0;
            c   = !rdy && (($urandom % 40) == 0);
            step(rdy, c);
            if (($urandom % 200) == 0) pulse_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
